// File: rtl/wb_gpio_ext_pkg.sv
// Shared definitions for the wb_gpio_ext peripheral: register word offsets,
// the register-select enum, the RW register set and a byte-lane mask helper.
package wb_gpio_ext_pkg;

  localparam logic [3:0] OFF_DIR        = 4'h0;
  localparam logic [3:0] OFF_OUT        = 4'h1;
  localparam logic [3:0] OFF_IN         = 4'h2;
  localparam logic [3:0] OFF_OUT_SET    = 4'h3;
  localparam logic [3:0] OFF_OUT_CLR    = 4'h4;
  localparam logic [3:0] OFF_OUT_TGL    = 4'h5;
  localparam logic [3:0] OFF_RISE_EN    = 4'h6;
  localparam logic [3:0] OFF_FALL_EN    = 4'h7;
  localparam logic [3:0] OFF_IRQ_STATUS = 4'h8;

  typedef enum logic [3:0] {
    REG_DIR        = OFF_DIR,
    REG_OUT        = OFF_OUT,
    REG_IN         = OFF_IN,
    REG_OUT_SET    = OFF_OUT_SET,
    REG_OUT_CLR    = OFF_OUT_CLR,
    REG_OUT_TGL    = OFF_OUT_TGL,
    REG_RISE_EN    = OFF_RISE_EN,
    REG_FALL_EN    = OFF_FALL_EN,
    REG_IRQ_STATUS = OFF_IRQ_STATUS
  } gpio_reg_e;

  typedef struct packed {
    logic [31:0] dir;
    logic [31:0] out;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
  } gpio_regs_t;

  // Expands the 4-bit byte select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/generic_synchronizer.sv
// Multi-bit flop-chain synchroniser for asynchronous level inputs.
// Each bit is synchronised independently; STAGES must be at least 2.
module generic_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= d;
    end
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg[gi] <= '0;
      end else begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gpio_irq_unit.sv
// Edge detection, pending-status bookkeeping and the registered interrupt line
// for the GPIO block. Edges are ignored until the input pipeline has settled.
module gpio_irq_unit
  import wb_gpio_ext_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] status,
  output logic             irq
);

  localparam int MASK_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(MASK_CYCLES + 1);

  logic [CNT_W-1:0] mask_cnt_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] status_reg, status_next;
  logic [WIDTH-1:0] edge_event;
  logic             irq_reg;
  logic             armed;

  // Synchroniser flops come out of reset at 0, so a pin held high looks like
  // a rising edge once it propagates; stay deaf until that has flushed.
  assign armed = (mask_cnt_reg == CNT_W'(MASK_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_cnt_reg <= '0;
    end else if (!armed) begin
      mask_cnt_reg <= mask_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    edge_event = '0;
    if (armed) begin
      edge_event = (pins & ~prev_reg & rise_en) | (~pins & prev_reg & fall_en);
    end
  end

  // A new event wins over a simultaneous software clear.
  assign status_next = (status_reg & ~clr) | edge_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg   <= '0;
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      prev_reg   <= pins;
      status_reg <= status_next;
      irq_reg    <= |status_reg;
    end
  end

  assign status = status_reg;
  assign irq    = irq_reg;

endmodule

// File: rtl/wb_gpio_ext.sv
// Wishbone GPIO peripheral with direction, atomic set/clear/toggle and edge IRQs.
// Define GPIO_DEBOUNCE_EN to insert a tick-based 3-sample filter after the synchroniser.
module wb_gpio_ext
  import wb_gpio_ext_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [5:0]       wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_stall_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [31:0] WIDTH_MASK =
    (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'h1 << WIDTH) - 32'h1);

  gpio_regs_t       regs_reg, regs_next;
  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic [31:0]      rd_data;
  logic [WIDTH-1:0] sync_pins;
  logic [WIDTH-1:0] pins;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] status_clr;
  logic             irq;
  gpio_reg_e        reg_sel;
  logic             access;
  logic             wr_access;
  logic [31:0]      wr_mask;
  logic [31:0]      wr_bits;
  logic             unused_adr_bits;

  assign unused_adr_bits = ^wb_adr_i[1:0];

  assign access    = wb_cyc_i & wb_stb_i;
  assign wr_access = access & wb_we_i;
  assign reg_sel   = gpio_reg_e'(wb_adr_i[5:2]);
  // Bits above WIDTH never get written, so they stay 0 and read back as 0.
  assign wr_mask   = lane_mask(wb_sel_i) & WIDTH_MASK;
  assign wr_bits   = wb_dat_i & wr_mask;

  always_comb begin
    regs_next  = regs_reg;
    status_clr = '0;
    if (wr_access) begin
      case (reg_sel)
        REG_DIR:        regs_next.dir     = (regs_reg.dir & ~wr_mask) | wr_bits;
        REG_OUT:        regs_next.out     = (regs_reg.out & ~wr_mask) | wr_bits;
        REG_OUT_SET:    regs_next.out     = regs_reg.out | wr_bits;
        REG_OUT_CLR:    regs_next.out     = regs_reg.out & ~wr_bits;
        REG_OUT_TGL:    regs_next.out     = regs_reg.out ^ wr_bits;
        REG_RISE_EN:    regs_next.rise_en = (regs_reg.rise_en & ~wr_mask) | wr_bits;
        REG_FALL_EN:    regs_next.fall_en = (regs_reg.fall_en & ~wr_mask) | wr_bits;
        REG_IRQ_STATUS: status_clr        = wr_bits[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DIR:        rd_data = regs_reg.dir;
      REG_OUT:        rd_data = regs_reg.out;
      REG_IN:         rd_data = 32'(pins);
      REG_RISE_EN:    rd_data = regs_reg.rise_en;
      REG_FALL_EN:    rd_data = regs_reg.fall_en;
      REG_IRQ_STATUS: rd_data = 32'(status);
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_reg <= '0;
      ack_reg  <= 1'b0;
      dat_reg  <= '0;
    end else begin
      regs_reg <= regs_next;
      ack_reg  <= access;
      dat_reg  <= (access && !wb_we_i) ? rd_data : '0;
    end
  end

  generic_synchronizer #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (gpio_i),
    .q     (sync_pins)
  );

`ifdef GPIO_DEBOUNCE_EN
  localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_W'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Filter output moves only when the last three tick samples agree.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filter
    logic [2:0] hist_reg;
    logic [2:0] hist_next;
    logic       filt_reg;

    assign hist_next = {hist_reg[1:0], sync_pins[gi]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hist_reg <= '0;
        filt_reg <= 1'b0;
      end else if (tick) begin
        hist_reg <= hist_next;
        if (hist_next == 3'b111) begin
          filt_reg <= 1'b1;
        end else if (hist_next == 3'b000) begin
          filt_reg <= 1'b0;
        end
      end
    end

    assign pins[gi] = filt_reg;
  end
`else
  localparam int unused_debounce_div = DEBOUNCE_DIV;
  assign pins = sync_pins;
`endif

  gpio_irq_unit #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .pins    (pins),
    .rise_en (regs_reg.rise_en[WIDTH-1:0]),
    .fall_en (regs_reg.fall_en[WIDTH-1:0]),
    .clr     (status_clr),
    .status  (status),
    .irq     (irq)
  );

  assign wb_dat_o   = dat_reg;
  assign wb_ack_o   = ack_reg;
  assign wb_stall_o = 1'b0;
  assign gpio_o     = regs_reg.out[WIDTH-1:0];
  assign gpio_oe_o  = regs_reg.dir[WIDTH-1:0];
  assign irq_o      = irq;

endmodule

// File: tb/tb_wb_gpio_ext.sv
// Directed self-checking bench for wb_gpio_ext (default parameters, no debounce).
module tb_wb_gpio_ext;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wb_cyc_i = 1'b0;
  logic             wb_stb_i = 1'b0;
  logic             wb_we_i = 1'b0;
  logic [5:0]       wb_adr_i = '0;
  logic [3:0]       wb_sel_i = '0;
  logic [31:0]      wb_dat_i = '0;
  logic [31:0]      wb_dat_o;
  logic             wb_ack_o;
  logic             wb_stall_o;
  logic [WIDTH-1:0] gpio_i = '0;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe_o;
  logic             irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_gpio_ext #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_DIV (1000)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_stall_o (wb_stall_o),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .gpio_oe_o  (gpio_oe_o),
    .irq_o      (irq_o)
  );

  // Single write beat after one idle cycle; reports ack before and after the edge.
  task automatic wb_write(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          output logic ack_pre, output logic ack_post);
    @(posedge clk); #1;
    ack_pre  = wb_ack_o;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    @(posedge clk); #1;
    ack_post = wb_ack_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    $display("write adr=%02h dat=%08h sel=%b ack_pre=%b ack=%b", adr, dat, sel, ack_pre, ack_post);
  endtask

  task automatic wb_read(input logic [5:0] adr, output logic [31:0] dat, output logic ack);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = adr;  wb_sel_i = 4'hF;
    @(posedge clk); #1;
    ack = wb_ack_o;
    dat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    $display("read  adr=%02h dat=%08h ack=%b", adr, dat, ack);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    gpio_i = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || gpio_oe_o !== '0 || gpio_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b ack=%b dat=%h oe=%h o=%h, required all 0",
               irq_o, wb_ack_o, wb_dat_o, gpio_oe_o, gpio_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_read(6'(i * 4), d, a);
      n_checks++;
      if (a !== 1'b1 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read_%0d: ack=%b dat=%h, required ack=1 dat=00000000", i, a, d);
      end
    end
  endtask

  task automatic test_out_ops();
    logic [5:0]  adrs [5];
    logic [31:0] dats [5];
    logic        ap, aq, a;
    logic [31:0] d;
    adrs[0] = 6'h00; dats[0] = 32'h0000_00FF;
    adrs[1] = 6'h04; dats[1] = 32'h0000_000F;
    adrs[2] = 6'h0C; dats[2] = 32'h0000_0030;
    adrs[3] = 6'h10; dats[3] = 32'h0000_0001;
    adrs[4] = 6'h14; dats[4] = 32'h0000_0081;
    for (int i = 0; i < 5; i++) begin
      wb_write(adrs[i], dats[i], 4'hF, ap, aq);
      n_checks++;
      if (ap !== 1'b0 || aq !== 1'b1) begin
        n_fail++;
        $display("FAIL out_ops_ack_%0d: ack before=%b after=%b, required 0 then 1", i, ap, aq);
      end
    end
    n_checks++;
    if (gpio_o !== 32'h0000_00BF || gpio_oe_o !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL out_ops_pins: gpio_o=%h oe=%h, required 000000bf 000000ff", gpio_o, gpio_oe_o);
    end
    wb_read(6'h04, d, a);
    n_checks++;
    if (d !== 32'h0000_00BF) begin
      n_fail++;
      $display("FAIL out_readback: got %h, required 000000bf", d);
    end
    wb_read(6'h0C, d, a);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL wo_reads_zero: got %h, required 00000000", d);
    end
  endtask

  task automatic test_byte_sel();
    logic        ap, aq, a;
    logic [31:0] d;
    wb_write(6'h00, 32'h0, 4'hF, ap, aq);
    wb_write(6'h00, 32'hFFFF_FFFF, 4'b0010, ap, aq);
    wb_read(6'h00, d, a);
    n_checks++;
    if (d !== 32'h0000_FF00 || gpio_oe_o !== 32'h0000_FF00) begin
      n_fail++;
      $display("FAIL sel_dir: dir=%h oe=%h, required 0000ff00", d, gpio_oe_o);
    end
    wb_write(6'h0C, 32'hFFFF_FFFF, 4'b0100, ap, aq);
    wb_read(6'h04, d, a);
    n_checks++;
    if (d !== 32'h00FF_00BF) begin
      n_fail++;
      $display("FAIL sel_set: out=%h, required 00ff00bf", d);
    end
    wb_write(6'h28, 32'h1234_5678, 4'hF, ap, aq);
    wb_read(6'h00, d, a);
    n_checks++;
    if (aq !== 1'b1 || d !== 32'h0000_FF00) begin
      n_fail++;
      $display("FAIL unmapped_write: ack=%b dir=%h, required 1 0000ff00", aq, d);
    end
  endtask

  task automatic test_rise_irq();
    logic        ap, aq, a;
    logic [31:0] d;
    wb_write(6'h18, 32'h1, 4'hF, ap, aq);
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    repeat (SYNC) @(posedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_irq_early: irq=%b, required 0", irq_o);
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 6'h20;
    @(posedge clk); #1;
    n_checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_status_pre: ack=%b st=%h irq=%b, required 1 00000000 0", wb_ack_o, wb_dat_o, irq_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1 || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_status_set: ack=%b st=%h irq=%b, required 1 00000001 1", wb_ack_o, wb_dat_o, irq_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_write(6'h20, 32'h1, 4'hF, ap, aq);
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq: irq=%b, required 0", irq_o);
    end
    wb_read(6'h20, d, a);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_status: got %h, required 00000000", d);
    end
  endtask

  task automatic test_w1c_race();
    logic        ap, aq, a;
    logic [31:0] d;
    wb_write(6'h1C, 32'h1, 4'hF, ap, aq);
    gpio_i[0] = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_irq: irq=%b, required 1", irq_o);
    end
    gpio_i[0] = 1'b1;
    repeat (SYNC) @(posedge clk);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 6'h20; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    n_checks++;
    if (wb_ack_o !== 1'b1 || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL race_ack: ack=%b irq=%b, required 1 1", wb_ack_o, irq_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL race_irq: irq=%b, required 1", irq_o);
    end
    wb_write(6'h18, 32'h0, 4'hF, ap, aq);
    wb_write(6'h1C, 32'h0, 4'hF, ap, aq);
    wb_read(6'h20, d, a);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL race_status_kept: got %h, required 00000001", d);
    end
    wb_write(6'h20, 32'h1, 4'hF, ap, aq);
    wb_read(6'h20, d, a);
    n_checks++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL race_cleanup: st=%h irq=%b, required 00000000 0", d, irq_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  adrs [4];
    logic [31:0] exps [4];
    logic        ap, aq;
    wb_write(6'h18, 32'h0000_00F0, 4'hF, ap, aq);
    gpio_i = 32'hA5A5_1235;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    adrs[0] = 6'h00; exps[0] = 32'h0000_FF00;
    adrs[1] = 6'h04; exps[1] = 32'h00FF_00BF;
    adrs[2] = 6'h08; exps[2] = 32'hA5A5_1235;
    adrs[3] = 6'h18; exps[3] = 32'h0000_00F0;
    n_checks++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_idle: ack=%b, required 0", wb_ack_o);
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wb_adr_i = adrs[i];
      n_checks++;
      if (wb_stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_stall_%0d: stall=%b, required 0", i, wb_stall_o);
      end
      @(posedge clk); #1;
      $display("burst beat %0d adr=%02h dat=%08h ack=%b", i, adrs[i], wb_dat_o, wb_ack_o);
      n_checks++;
      if (wb_ack_o !== 1'b1 || wb_dat_o !== exps[i]) begin
        n_fail++;
        $display("FAIL burst_beat_%0d: ack=%b dat=%h, required 1 %h", i, wb_ack_o, wb_dat_o, exps[i]);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL burst_end: ack=%b dat=%h, required 0 00000000", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_reset_hold();
    logic [31:0] d;
    logic        a;
    gpio_i = 32'hFFFF_FFFF;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 6'h18; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    n_checks++;
    if (wb_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ack: ack=%b, required 1", wb_ack_o);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_irq: irq=%b, required 0", irq_o);
    end
    wb_read(6'h20, d, a);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_status: got %h, required 00000000", d);
    end
    wb_read(6'h08, d, a);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL hold_in: got %h, required ffffffff", d);
    end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_byte_sel();
    test_rise_irq();
    test_w1c_race();
    test_back_to_back();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
